rr_bus_arbiter: RTL
===================

# rr_bus_arbiter

Round-robin arbiter with tenure limit for the shared system bus. It takes one request line per bus master and issues a registered one-hot grant. A master keeps the grant while it holds its request, but loses it after a bounded tenure if another master is waiting. Every handover inserts one dead cycle for bus turnaround. It replaces fixed-priority granting on the bus so that no master can be starved.

## Interface
- `N_REQ`, default 4: number of requesters, valid range 2..16.
- `MAX_TENURE`, default 16: maximum consecutive grant cycles while another request is pending, valid range 2..256.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `i_request` in N_REQ: request line per master; bit k belongs to master k.
- `o_grant` out N_REQ: registered grant, one-hot or all-zero.
- `o_grant_id` out $clog2(N_REQ): index of the current owner; 0 when no grant is active.
- `o_bus_busy` out 1: high in GRANT and RELEASE.
- `o_preempt` out 1: one-cycle pulse on the first RELEASE cycle caused by tenure expiry.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- Arbitration
  - Winner is the first set bit of `i_request` scanning from `ptr` upward, with wrap-around modulo N_REQ.
  - `ptr` resets to 0.
  - On every transition GRANT→RELEASE, `ptr` becomes owner+1 mod N_REQ.
- IDLE
  - If `i_request`≠0: go to GRANT. Latch the winner as owner and clear `tenure`.
  - Otherwise stay in IDLE.
- GRANT
  - Drive `o_grant` = 1<<owner.
  - `tenure` increments each cycle and saturates at MAX_TENURE-1.
  - Go to RELEASE if `i_request[owner]`=0.
  - Also go to RELEASE if `tenure`==MAX_TENURE-1 and any other request bit is set. This is a preemption, and `o_preempt`=1 in the next cycle.
  - Otherwise stay in GRANT. With no competitor, the owner may hold indefinitely.
- RELEASE
  - `o_grant`=0 for exactly one cycle.
  - If `i_request`≠0: go to GRANT with a new winner, computed from the updated `ptr`. The preempted master is eligible again, at the lowest rotation priority.
  - Otherwise go to IDLE.
- Reset
  - Any state goes to IDLE, `ptr`=0, `tenure`=0.
  - All outputs are 0 in the cycle after the reset edge.
  - Reset mid-grant drops the grant with no RELEASE cycle and no `o_preempt`.
- Boundary cases
  - Owner drops its request on the same edge that tenure expires: treated as a normal release, `o_preempt`=0.
  - A new request arriving during RELEASE is considered at that edge.
  - Out-of-range `ptr` is impossible by construction. Assert it in simulation.

## Timing
- Grant latency from IDLE: a request sampled at edge n gives `o_grant` high from edge n+1.
- Release latency: owner request low at edge n gives grant low from edge n+1 (RELEASE), and the next owner's grant from edge n+2.
- Maximum tenure under contention: MAX_TENURE cycles of grant, then 1 dead cycle.
- Worst-case wait for a continuously requesting master: (N_REQ-1)·(MAX_TENURE+1) cycles after the first edge at which it is sampled.
- All outputs come straight from registers. No combinational path exists from `i_request` to any output.

## Structure
- Shared package `bus_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT, RELEASE}
  - default constants `ARB_N_REQ`=4 and `ARB_MAX_TENURE`=16
- Sub-module `rr_priority_pick`: purely combinational rotate, priority-encode, rotate-back. Inputs are `req` and `ptr`; outputs are `valid` and `idx`. Instantiated once.
- The top level holds the FSM, owner, `ptr` and `tenure` registers, and output registers.

## Test plan
- Reset, then `i_request`=4'b1010 held → grant 4'b0010 (id 1) from the next edge.
- Drop `i_request[1]` → 1 cycle of `o_grant`=0, then grant 4'b1000 (id 3).
- `i_request`=4'b1111 held, MAX_TENURE=16 → grants rotate 0→1→2→3→0.
  - Each grant lasts 16 cycles, separated by single zero cycles.
  - `o_preempt` pulses on each zero cycle.
- Only master 2 requesting for 100 cycles → grant 4'b0100 throughout, `o_preempt` never set.
- Owner drops its request on the same edge its tenure expires, with a competitor waiting → RELEASE, `o_preempt`=0.
- Assert `Reset` during GRANT → `o_grant`=0, `o_bus_busy`=0 next cycle. After reset is released with 4'b1111, master 0 wins first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin system bus arbiter.
//
// Contents:
//   arb_state_t    - arbiter FSM state encoding (IDLE, GRANT, RELEASE)
//   ARB_N_REQ      - default number of bus masters
//   ARB_MAX_TENURE - default grant tenure (cycles) while another master waits
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_N_REQ      = 4;
  localparam int ARB_MAX_TENURE = 16;

endpackage : bus_arb_pkg

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
//
// Finds the first set bit of req, scanning upward from position ptr with
// wrap-around modulo N.
//
// Ports:
//   req   [N-1:0]          - request vector, bit k belongs to master k
//   ptr   [$clog2(N)-1:0]  - position with highest priority this cycle
//   valid                  - at least one request bit is set
//   idx   [$clog2(N)-1:0]  - index of the winning request (0 when !valid)
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);
  localparam logic [W:0] NUM = (W+1)'(N);

  logic [N-1:0] rotated;
  logic [W-1:0] offset;
  logic [W:0]   sum;

  // Rotate the request vector so that position ptr lands on bit 0. The
  // index is folded back into range by one conditional subtract, which
  // also handles request counts that are not a power of two.
  always_comb begin
    rotated = '0;
    for (int j = 0; j < N; j++) begin
      int k;
      k = j + int'(ptr);
      if (k >= N) begin
        k = k - N;
      end
      rotated[j] = req[k];
    end
  end

  // Priority-encode the rotated vector; the lowest set bit wins, so the
  // loop runs downward and the last hit is kept.
  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        valid  = 1'b1;
        offset = W'(j);
      end
    end
  end

  // Rotate the winning offset back into absolute master numbering.
  always_comb begin
    sum = {1'b0, offset} + {1'b0, ptr};
    if (sum >= NUM) begin
      sum = sum - NUM;
    end
    idx = valid ? sum[W-1:0] : '0;
  end

endmodule : rr_priority_pick

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with a bounded tenure under contention.
//
// A master keeps the bus while it holds its request. If another master is
// waiting, the owner is preempted after MAX_TENURE grant cycles. Every
// handover inserts one dead (RELEASE) cycle for bus turnaround. All outputs
// are registered; nothing on i_request reaches an output combinationally.
//
// Ports:
//   Clock       - rising-edge clock
//   Reset       - synchronous, active-high reset
//   i_request   - one request line per master
//   o_grant     - registered one-hot grant, or all-zero
//   o_grant_id  - index of the current owner, 0 when no grant is active
//   o_bus_busy  - high while in GRANT or RELEASE
//   o_preempt   - one-cycle pulse on a RELEASE cycle caused by tenure expiry
module rr_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ      = ARB_N_REQ,
  parameter int MAX_TENURE = ARB_MAX_TENURE
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         i_request,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_bus_busy,
  output logic                     o_preempt
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TEN_W = $clog2(MAX_TENURE);
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [TEN_W-1:0] tenure_q, tenure_d;

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] grantId_q, grantId_d;
  logic             busBusy_q, busBusy_d;
  logic             preempt_q, preempt_d;

  logic             pickValid;
  logic [PTR_W-1:0] pickIdx;
  logic [N_REQ-1:0] ownerMask;
  logic             ownerReq;
  logic             otherReq;
  logic [PTR_W-1:0] nextPtr;

  rr_priority_pick #(
    .N(N_REQ)
  ) u_pick (
    .req  (i_request),
    .ptr  (ptr_q),
    .valid(pickValid),
    .idx  (pickIdx)
  );

  assign ownerMask = N_REQ'(1) << owner_q;
  assign ownerReq  = |(i_request & ownerMask);
  assign otherReq  = |(i_request & ~ownerMask);
  assign nextPtr   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Next-state logic. The pointer only moves when a grant ends, so the
  // master that just released ends up at the lowest rotation priority.
  // A release by the owner dropping its request takes precedence over
  // tenure expiry, so that case never raises o_preempt.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tenure_d  = tenure_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d  = GRANT;
          owner_d  = pickIdx;
          tenure_d = '0;
        end
      end

      GRANT: begin
        if (tenure_q != TEN_LAST) begin
          tenure_d = tenure_q + 1'b1;
        end
        if (!ownerReq) begin
          state_d = RELEASE;
          ptr_d   = nextPtr;
        end else if ((tenure_q == TEN_LAST) && otherReq) begin
          state_d   = RELEASE;
          ptr_d     = nextPtr;
          preempt_d = 1'b1;
        end
      end

      RELEASE: begin
        if (pickValid) begin
          state_d  = GRANT;
          owner_d  = pickIdx;
          tenure_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // alongside it and still appear in the cycle the state is entered.
  always_comb begin
    grant_d   = '0;
    grantId_d = '0;
    busBusy_d = (state_d != IDLE);
    if (state_d == GRANT) begin
      grant_d   = N_REQ'(1) << owner_d;
      grantId_d = owner_d;
    end
  end

  // State, arbitration and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      tenure_q  <= '0;
      grant_q   <= '0;
      grantId_q <= '0;
      busBusy_q <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tenure_q  <= tenure_d;
      grant_q   <= grant_d;
      grantId_q <= grantId_d;
      busBusy_q <= busBusy_d;
      preempt_q <= preempt_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_grant_id = grantId_q;
  assign o_bus_busy = busBusy_q;
  assign o_preempt  = preempt_q;

  // The pointer and owner are only ever loaded with in-range indices.
  ptrInRange: assert property (@(posedge Clock) disable iff (Reset)
    (int'(ptr_q) < N_REQ) && (int'(owner_q) < N_REQ));

endmodule : rr_bus_arbiter
